// File: rtl/cache_pkg.sv
//============================================================================
// cache_pkg : shared types and address-field width helpers for cache_sa_ctrl
// Revision  : 1.0 - initial release
//============================================================================
`default_nettype none

package cache_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_WRITEBACK = 3'd2,
        S_REFILL    = 3'd3,
        S_RESPOND   = 3'd4
    } state_t;

    localparam int BYTE_OFF_W  = 2;
    localparam int TAG_STORE_W = 32;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int offset_width(input int words_per_block);
        return BYTE_OFF_W + $clog2(words_per_block);
    endfunction

    function automatic int index_width(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_width(input int addr_w, input int words_per_block,
                                     input int num_sets);
        return addr_w - offset_width(words_per_block) - index_width(num_sets);
    endfunction

    // Tag field is stored zero-extended so one struct type serves any geometry.
    typedef struct packed {
        logic                   valid;
        logic                   dirty;
        logic [TAG_STORE_W-1:0] tag;
    } line_meta_t;

endpackage

`default_nettype wire

// File: rtl/cache_lru.sv
//============================================================================
// cache_lru : per-set age-based LRU tracker (touch port + victim query)
// Revision  : 1.0 - initial release
//============================================================================
`default_nettype none

module cache_lru
    import cache_pkg::*;
#(
    parameter int NUM_SETS = 4,
    parameter int NUM_WAYS = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            touch_en,
    input  logic [clog2_min1(NUM_SETS)-1:0] touch_set,
    input  logic [clog2_min1(NUM_WAYS)-1:0] touch_way,
    input  logic [clog2_min1(NUM_SETS)-1:0] query_set,
    output logic [clog2_min1(NUM_WAYS)-1:0] victim_way
);

    localparam int WAY_W = clog2_min1(NUM_WAYS);

    logic [WAY_W-1:0] age [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0] best_age;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    age[s][w] <= WAY_W'(w);
                end
            end
        end else if (touch_en) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (WAY_W'(w) == touch_way) begin
                    age[touch_set][w] <= '0;
                end else if (age[touch_set][w] < age[touch_set][touch_way]) begin
                    age[touch_set][w] <= age[touch_set][w] + 1'b1;
                end
            end
        end
    end

    // Ages form a permutation, so the oldest way is the unique maximum.
    always_comb begin
        victim_way = '0;
        best_age   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (age[query_set][w] > best_age) begin
                best_age   = age[query_set][w];
                victim_way = WAY_W'(w);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/cache_sa_ctrl.sv
//============================================================================
// cache_sa_ctrl : set-associative write-back, write-allocate cache controller
//                 with LRU replacement. Define CACHE_STATS_EN for hit/miss
//                 counters.
// Revision      : 1.0 - initial release
//============================================================================
`default_nettype none

module cache_sa_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W          = 10,
    parameter int WORD_W          = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int NUM_SETS        = 4,
    parameter int NUM_WAYS        = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              cpuReq,
    input  logic                              isRead,
    input  logic [ADDR_W-1:0]                 address,
    input  logic [WORD_W-1:0]                 writeData,
    output logic                              cpuReady,
    output logic [WORD_W-1:0]                 readData,
    output logic                              isHit,
    output logic                              memReq,
    output logic                              isMemRead,
    output logic [ADDR_W-1:0]                 memAddress,
    output logic [WORD_W*WORDS_PER_BLOCK-1:0] memWriteData,
    input  logic [WORD_W*WORDS_PER_BLOCK-1:0] memReadData,
    input  logic                              memReady
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]                       hitCount,
    output logic [15:0]                       missCount
`endif
);

    localparam int OFF_W   = offset_width(WORDS_PER_BLOCK);
    localparam int IDX_W   = index_width(NUM_SETS);
    localparam int TAG_W   = tag_width(ADDR_W, WORDS_PER_BLOCK, NUM_SETS);
    localparam int WSEL_W  = OFF_W - BYTE_OFF_W;
    localparam int WAY_W   = clog2_min1(NUM_WAYS);
    localparam int BLOCK_W = WORD_W * WORDS_PER_BLOCK;

    state_t                   state;
    logic                     req_read;
    logic [ADDR_W-1:BYTE_OFF_W] req_addr;
    logic [WORD_W-1:0]        req_wdata;
    logic [WAY_W-1:0]         way_r;

    line_meta_t               meta     [NUM_SETS][NUM_WAYS];
    logic [BLOCK_W-1:0]       data_mem [NUM_SETS][NUM_WAYS];

    logic [WSEL_W-1:0]        req_word;
    logic [IDX_W-1:0]         req_index;
    logic [TAG_W-1:0]         req_tag;
    logic [ADDR_W-1:0]        req_block_addr;

    logic                     hit;
    logic [WAY_W-1:0]         hit_way;
    logic                     inv_found;
    logic [WAY_W-1:0]         inv_way;
    logic [WAY_W-1:0]         lru_victim;
    logic [WAY_W-1:0]         victim_way;
    line_meta_t               victim_meta;
    logic [BLOCK_W-1:0]       hit_block;
    logic                     unused_addr_lsbs;

    assign unused_addr_lsbs = ^address[BYTE_OFF_W-1:0];

    assign req_word       = req_addr[OFF_W-1:BYTE_OFF_W];
    assign req_index      = req_addr[OFF_W+IDX_W-1:OFF_W];
    assign req_tag        = req_addr[ADDR_W-1:OFF_W+IDX_W];
    assign req_block_addr = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Hit search plus lowest-index invalid way, both over the addressed set.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!hit && meta[req_index][w].valid &&
                meta[req_index][w].tag == TAG_STORE_W'(req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !meta[req_index][w].valid) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
    end

    assign victim_way  = inv_found ? inv_way : lru_victim;
    assign victim_meta = meta[req_index][victim_way];
    assign hit_block   = data_mem[req_index][hit_way];

    cache_lru #(
        .NUM_SETS (NUM_SETS),
        .NUM_WAYS (NUM_WAYS)
    ) u_lru (
        .clk        (clk),
        .reset      (reset),
        .touch_en   (state == S_RESPOND),
        .touch_set  (req_index),
        .touch_way  (way_r),
        .query_set  (req_index),
        .victim_way (lru_victim)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            req_read     <= 1'b0;
            req_addr     <= '0;
            req_wdata    <= '0;
            way_r        <= '0;
            cpuReady     <= 1'b0;
            readData     <= '0;
            isHit        <= 1'b0;
            memReq       <= 1'b0;
            isMemRead    <= 1'b0;
            memAddress   <= '0;
            memWriteData <= '0;
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    meta[s][w] <= '0;
                end
            end
        end else begin
            cpuReady <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cpuReq) begin
                        req_read  <= isRead;
                        req_addr  <= address[ADDR_W-1:BYTE_OFF_W];
                        req_wdata <= writeData;
                        state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        way_r    <= hit_way;
                        cpuReady <= 1'b1;
                        isHit    <= 1'b1;
                        readData <= hit_block[req_word*WORD_W +: WORD_W];
                        state    <= S_RESPOND;
                    end else begin
                        way_r  <= victim_way;
                        memReq <= 1'b1;
                        if (victim_meta.valid && victim_meta.dirty) begin
                            isMemRead    <= 1'b0;
                            memAddress   <= {victim_meta.tag[TAG_W-1:0], req_index,
                                             {OFF_W{1'b0}}};
                            memWriteData <= data_mem[req_index][victim_way];
                            state        <= S_WRITEBACK;
                        end else begin
                            isMemRead    <= 1'b1;
                            memAddress   <= req_block_addr;
                            memWriteData <= '0;
                            state        <= S_REFILL;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (memReady) begin
                        isMemRead    <= 1'b1;
                        memAddress   <= req_block_addr;
                        memWriteData <= '0;
                        state        <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (memReady) begin
                        memReq            <= 1'b0;
                        isMemRead         <= 1'b0;
                        memAddress        <= '0;
                        meta[req_index][way_r] <= '{valid: 1'b1, dirty: 1'b0,
                                                    tag: TAG_STORE_W'(req_tag)};
                        cpuReady          <= 1'b1;
                        isHit             <= 1'b0;
                        readData          <= memReadData[req_word*WORD_W +: WORD_W];
                        state             <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    if (!req_read) begin
                        meta[req_index][way_r].dirty <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Block storage carries no reset; only metadata decides what is live.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == S_REFILL && memReady) begin
                data_mem[req_index][way_r] <= memReadData;
            end else if (state == S_RESPOND && !req_read) begin
                data_mem[req_index][way_r][req_word*WORD_W +: WORD_W] <= req_wdata;
            end
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hitCount  <= '0;
            missCount <= '0;
        end else if (state == S_RESPOND) begin
            if (isHit) begin
                if (hitCount != 16'hFFFF) hitCount <= hitCount + 16'd1;
            end else begin
                if (missCount != 16'hFFFF) missCount <= missCount + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
